// File: rtl/raw10_byte_packer_pkg.sv
// Shared constants and types for the RAW10 byte packer and its output FIFO.
package raw10_byte_packer_pkg;

  localparam int C_PIX_W       = 10;
  localparam int C_GROUP_PIX   = 4;
  localparam int C_GROUP_BYTES = 5;
  localparam int C_ENTRY_W     = 10;

  // One MSB byte plus at most one flushed LSB byte can land in a single cycle.
  localparam int C_MAX_WR = C_GROUP_BYTES - C_GROUP_PIX + 1;
  localparam int C_NWR_W  = $clog2(C_MAX_WR + 1);
  localparam int C_CNT_W  = $clog2(C_GROUP_PIX);

  typedef struct packed {
    logic       sof;
    logic       eol;
    logic [7:0] data;
  } entry_t;

  function automatic entry_t make_entry(input logic sof, input logic eol, input logic [7:0] data);
    entry_t e;
    e.sof  = sof;
    e.eol  = eol;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/raw10_byte_packer_pack_fifo.sv
// First-word-fall-through byte FIFO with two write ports and one read port.
module pack_fifo
  import raw10_byte_packer_pkg::*;
#(
  parameter int G_DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en0,
  input  entry_t                     wr_data0,
  input  logic                       wr_en1,
  input  entry_t                     wr_data1,
  input  logic                       rd_en,
  output entry_t                     rd_data,
  output logic                       rd_vld,
  output logic [$clog2(G_DEPTH):0]   free
);

  localparam int AW = $clog2(G_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(G_DEPTH);

  logic [C_ENTRY_W-1:0] mem [G_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        wr_ptr_nxt1;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        occ;
  logic [CW-1:0]        n_push;
  logic                 pop;

  assign pop         = rd_en & rd_vld;
  assign n_push      = CW'(wr_en0) + CW'(wr_en1);
  assign wr_ptr_nxt1 = wr_ptr + AW'(1);
  assign rd_vld      = (occ != '0);
  assign rd_data     = entry_t'(mem[rd_ptr]);
  // A pop in the same cycle frees its slot for this cycle's writes.
  assign free        = C_DEPTH - occ + CW'(pop);

  // Storage array; second write lands just after the first.
  always_ff @(posedge clk) begin
    if (wr_en0) mem[wr_ptr]      <= wr_data0;
    if (wr_en1) mem[wr_ptr_nxt1] <= wr_data1;
  end

  // Pointers wrap naturally at the power-of-two depth; occupancy tracks both sides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_push);
      rd_ptr <= rd_ptr + AW'(pop);
      occ    <= occ + n_push - CW'(pop);
    end
  end

endmodule

// File: rtl/raw10_byte_packer.sv
// Packs 10-bit pixels into RAW10 byte groups (4 MSB bytes + 1 LSB byte) and
// queues them, tagged with start-of-frame / end-of-line, in an output FIFO.
module raw10_byte_packer
  import raw10_byte_packer_pkg::*;
#(
  parameter int G_FIFO_DEPTH = 32
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic               FRAME_START,
  input  logic [C_PIX_W-1:0] PIX_IN,
  input  logic               PIX_VALID,
  input  logic               LINE_END,
  output logic [7:0]         BYTE_OUT,
  output logic               BYTE_SOF,
  output logic               BYTE_EOL,
  output logic               BYTE_VALID,
  input  logic               BYTE_READY,
  output logic               OVERFLOW,
  output logic               PROTOCOL_ERR
);

  localparam int CW = $clog2(G_FIFO_DEPTH) + 1;

  logic                              rst_n_sync;
  logic                              vld_p0, fs_p0, le_p0;
  logic [C_PIX_W-1:0]                pix_p0;
  logic [C_CNT_W-1:0]                cnt_q, cnt_d;
  logic [C_GROUP_PIX-1:0][1:0]       slots_q, slots_d;
  logic                              pend_vld_q, pend_vld_d;
  logic [7:0]                        pend_byte_q, pend_byte_d;
  logic                              sof_arm_q, sof_arm_d;
  logic                              le_defer_q, le_defer_d;
  logic                              ovf_q, ovf_d;
  logic                              le_act, sof_now, eol0, drop;
  logic [C_NWR_W-1:0]                n_wr;
  logic [7:0]                        byte0, byte1;
  logic                              wr_en0, wr_en1;
  entry_t                            head;
  logic                              head_vld;
  logic [CW-1:0]                     fifo_free;

  // Assert asynchronously, release on the next edge so logic runs from the second edge.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) rst_n_sync <= 1'b0;
    else          rst_n_sync <= 1'b1;
  end

  // ---- stage p0: input capture ----
  // Input control strobes registered; this stage sets the one-cycle write latency.
  always_ff @(posedge CLOCK or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      vld_p0 <= 1'b0;
      fs_p0  <= 1'b0;
      le_p0  <= 1'b0;
    end else begin
      vld_p0 <= PIX_VALID;
      fs_p0  <= FRAME_START;
      le_p0  <= LINE_END;
    end
  end

  // Pixel data travels alongside vld_p0 without reset.
  always_ff @(posedge CLOCK) begin
    pix_p0 <= PIX_IN;
  end

  // ---- stage p0 -> FIFO: packing decisions ----
  // Order within a cycle: frame start, then line end, then the pixel.
  always_comb begin
    cnt_d       = cnt_q;
    slots_d     = slots_q;
    pend_vld_d  = pend_vld_q;
    pend_byte_d = pend_byte_q;
    sof_arm_d   = sof_arm_q;
    ovf_d       = ovf_q;
    le_defer_d  = vld_p0 & le_p0;
    le_act      = (le_defer_q & ~fs_p0) | (le_p0 & ~vld_p0);
    n_wr        = '0;
    byte0       = '0;
    byte1       = '0;
    eol0        = 1'b0;
    drop        = 1'b0;

    if (fs_p0) begin
      cnt_d      = '0;
      slots_d    = '0;
      pend_vld_d = 1'b0;
      sof_arm_d  = 1'b1;
    end
    sof_now = sof_arm_d;

    if (le_act) begin
      if (pend_vld_d) begin
        byte0 = pend_byte_d;
        eol0  = 1'b1;
        n_wr  = C_NWR_W'(1);
      end else if (cnt_d != '0) begin
        // Unreceived slots were cleared, so they read as zero fields.
        byte0 = slots_d;
        eol0  = 1'b1;
        n_wr  = C_NWR_W'(1);
      end
      cnt_d      = '0;
      slots_d    = '0;
      pend_vld_d = 1'b0;
    end

    if (vld_p0) begin
      if (pend_vld_d) begin
        byte0      = pend_byte_d;
        n_wr       = C_NWR_W'(1);
        pend_vld_d = 1'b0;
      end
      if (n_wr == '0) byte0 = pix_p0[C_PIX_W-1:2];
      else            byte1 = pix_p0[C_PIX_W-1:2];
      n_wr           = n_wr + C_NWR_W'(1);
      slots_d[cnt_d] = pix_p0[1:0];
      if (cnt_d == C_CNT_W'(C_GROUP_PIX - 1)) begin
        pend_byte_d = slots_d;
        pend_vld_d  = 1'b1;
        cnt_d       = '0;
        slots_d     = '0;
      end else begin
        cnt_d = cnt_d + C_CNT_W'(1);
      end
    end

    // All-or-nothing: a cycle that does not fit is dropped whole.
    if (n_wr != '0) begin
      drop = (CW'(n_wr) > fifo_free);
      if (drop) ovf_d     = 1'b1;
      else      sof_arm_d = 1'b0;
    end
  end

  assign wr_en0 = (n_wr != '0) & ~drop;
  assign wr_en1 = (n_wr == C_NWR_W'(2)) & ~drop;

  // Packer state; slots and pending byte are cleared because line/frame logic depends on them.
  always_ff @(posedge CLOCK or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      cnt_q       <= '0;
      slots_q     <= '0;
      pend_vld_q  <= 1'b0;
      pend_byte_q <= '0;
      sof_arm_q   <= 1'b0;
      le_defer_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      slots_q     <= slots_d;
      pend_vld_q  <= pend_vld_d;
      pend_byte_q <= pend_byte_d;
      sof_arm_q   <= sof_arm_d;
      le_defer_q  <= le_defer_d;
      ovf_q       <= ovf_d;
    end
  end

  pack_fifo #(
    .G_DEPTH (G_FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLOCK),
    .rst_n    (rst_n_sync),
    .wr_en0   (wr_en0),
    .wr_data0 (make_entry(sof_now, eol0, byte0)),
    .wr_en1   (wr_en1),
    .wr_data1 (make_entry(1'b0, 1'b0, byte1)),
    .rd_en    (BYTE_READY),
    .rd_data  (head),
    .rd_vld   (head_vld),
    .free     (fifo_free)
  );

  // Head fields are forced low when empty so stale storage never shows.
  assign BYTE_VALID   = head_vld;
  assign BYTE_OUT     = head_vld ? head.data : 8'h00;
  assign BYTE_SOF     = head_vld & head.sof;
  assign BYTE_EOL     = head_vld & head.eol;
  assign OVERFLOW     = ovf_q;
  assign PROTOCOL_ERR = vld_p0 & le_p0;

endmodule
